line_mem_bridge: RTL and testbench
==================================

# line_mem_bridge

Memory-side responder for the 256-bit line request protocol issued by the MMU (and any other line initiator): accepts a line read or write on `addr_i`/`rd_i`/`we_i`, returns `ack_o`, and serialises the line into eight 32-bit beats on a word-wide downstream memory bus. It sits between the MMU's physical port and the word memory/controller. It includes a per-beat timeout so a dead downstream slave cannot hang the initiator.

## Interface
- `TIMEOUT_CYCLES`, 1023, 10-bit count of strobe-high cycles without `mem_ack_i` before a beat is aborted; 0 disables the timeout.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `addr_i`  in  32  line address from initiator; bits [4:0] ignored.
- `data_i`  in  256  write line; word k = bits [32k+31:32k].
- `data_o`  out  256  read line; valid only while `ack_o`=1.
- `rd_i`  in  1  line read request, held by initiator until `ack_o`.
- `we_i`  in  1  line write request, held until `ack_o`; priority over `rd_i`.
- `ack_o`  out  1  one-cycle completion pulse.
- `err_o`  out  1  pulses with `ack_o` when the transaction was aborted by timeout.
- `mem_addr_o`  out  32  beat word address.
- `mem_data_o`  out  32  beat write word.
- `mem_data_i`  in  32  beat read word, sampled in `mem_ack_i` cycle.
- `mem_rd_o`  out  1  beat read strobe.
- `mem_we_o`  out  1  beat write strobe.
- `mem_ack_i`  in  1  beat completion from downstream.

## Operation
- States: S_IDLE, S_READ, S_WRITE, S_DONE.
- S_IDLE: if `we_i` → latch `addr_i[31:5]`, `data_i`, beat index k=0, go S_WRITE; else if `rd_i` → latch address, clear line buffer to 0, k=0, go S_READ; else stay.
- S_READ/S_WRITE per beat: `mem_addr_o` = {line[31:5], k[2:0], 2'b00}; `mem_data_o` = word k of latched line; strobe (`mem_rd_o` or `mem_we_o`) high until `mem_ack_i`. On `mem_ack_i`: read captures `mem_data_i` into buffer word k; strobe drops for exactly one gap cycle; k increments. After k=7 acked → S_DONE.
- `mem_ack_i` is ignored in gap cycles and in S_IDLE/S_DONE.
- Timeout: counter cleared on each strobe rise, increments each strobe-high cycle without ack; reaching `TIMEOUT_CYCLES` drops strobe, skips remaining beats, sets error flag, → S_DONE. Unreceived read words remain 0.
- S_DONE: `ack_o`=1, `err_o`=error flag, `data_o`=buffer; next state S_IDLE. Requests seen in S_DONE are not accepted (mandatory one-cycle turnaround).
- Reset (any state, incl. mid-burst): state S_IDLE, k=0, counter 0, error flag 0; strobes low from next cycle; no `ack_o` issued for the aborted transaction.
- Reset values: `ack_o`, `err_o`, `mem_rd_o`, `mem_we_o` = 0; `data_o`, `mem_addr_o`, `mem_data_o` = 0.

## Timing
- All outputs registered.
- Cycle 0 = first cycle request seen in S_IDLE. Beat 0 strobe high from cycle 1.
- Zero-wait downstream (ack in first strobe cycle): beat k strobe in cycle 2k+1, gap in 2k+2; `ack_o` in cycle 16; S_IDLE in cycle 17, new request acceptable in cycle 17.
- Each wait state adds one cycle to its beat.
- Timeout on beat k: strobe high `TIMEOUT_CYCLES` cycles, then `ack_o`+`err_o` next cycle.
- `rd_i` and `we_i` both high: write only, one `ack_o`.
- Request deasserted before `ack_o`: transaction still completes and acks.

## Test plan
- Read, zero-wait memory returning word = 0x1000_0000+k, `addr_i`=0x0000_2013 → addresses 0x2000..0x201C, `ack_o` cycle 16, `data_o` word k = 0x1000_000k, `err_o`=0.
- Write line with word k = 0xA5A5_0000+k to 0x0040_0000, memory 3 wait states per beat → `mem_we_o` beats with matching address/data, one gap cycle each, `ack_o` at cycle 40.
- Read with `mem_ack_i` withheld on beat 3, `TIMEOUT_CYCLES`=4 → strobe drops after 4 cycles, no beats 4–7, `ack_o`=`err_o`=1, words 0–2 valid, words 3–7 = 0.
- Back-to-back: `rd_i` held high through `ack_o` → no acceptance in S_DONE, second read begins with strobe in cycle 18.
- `rst` asserted during beat 5 of a write → strobe low next cycle, no `ack_o`, all outputs at reset values; subsequent read completes normally.
- `rd_i`=`we_i`=1 together → only `mem_we_o` beats, single `ack_o`.

Source files
------------

// File: rtl/line_mem_bridge.sv
// Line-to-word bridge: serialises a 256-bit line read/write into eight 32-bit
// downstream beats, with a per-beat timeout so a dead slave cannot hang the initiator.
module line_mem_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    output logic [255:0] data_o,
    input  logic         rd_i,
    input  logic         we_i,
    output logic         ack_o,
    output logic         err_o,
    output logic [31:0]  mem_addr_o,
    output logic [31:0]  mem_data_o,
    input  logic [31:0]  mem_data_i,
    output logic         mem_rd_o,
    output logic         mem_we_o,
    input  logic         mem_ack_i
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_e;

    localparam logic [10:0] TimeoutLim = 11'(TIMEOUT_CYCLES);

    state_e         state_q, state_d;
    logic [2:0]     beat_q, beat_d;
    logic [9:0]     cnt_q, cnt_d;
    logic [26:0]    line_q, line_d;
    logic [255:0]   wdata_q, wdata_d;
    logic [255:0]   buf_q, buf_d;
    logic           ack_q, ack_d;
    logic           err_q, err_d;
    logic           mem_rd_q, mem_rd_d;
    logic           mem_we_q, mem_we_d;
    logic [31:0]    mem_addr_q, mem_addr_d;
    logic [31:0]    mem_data_q, mem_data_d;
    logic           strobe;
    logic           timeout_hit;

    // Line offset bits carry no meaning for a whole-line transfer.
    logic unused_addr;
    assign unused_addr = ^addr_i[4:0];

    assign strobe      = mem_rd_q | mem_we_q;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (({1'b0, cnt_q} + 11'd1) == TimeoutLim);

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        cnt_d      = cnt_q;
        line_d     = line_q;
        wdata_d    = wdata_q;
        buf_d      = buf_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        mem_rd_d   = mem_rd_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;

        unique case (state_q)
            S_IDLE: begin
                if (we_i) begin
                    line_d     = addr_i[31:5];
                    wdata_d    = data_i;
                    beat_d     = 3'd0;
                    cnt_d      = '0;
                    mem_we_d   = 1'b1;
                    mem_addr_d = {addr_i[31:5], 5'b00000};
                    mem_data_d = data_i[31:0];
                    state_d    = S_WRITE;
                end else if (rd_i) begin
                    line_d     = addr_i[31:5];
                    buf_d      = '0;
                    beat_d     = 3'd0;
                    cnt_d      = '0;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = {addr_i[31:5], 5'b00000};
                    state_d    = S_READ;
                end
            end

            S_READ, S_WRITE: begin
                if (!strobe) begin
                    // Gap cycle: raise the strobe for the next beat, ack is ignored here.
                    mem_rd_d   = (state_q == S_READ);
                    mem_we_d   = (state_q == S_WRITE);
                    mem_addr_d = {line_q, beat_q, 2'b00};
                    mem_data_d = wdata_q[{beat_q, 5'd0} +: 32];
                    cnt_d      = '0;
                end else if (mem_ack_i) begin
                    mem_rd_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (state_q == S_READ) begin
                        buf_d[{beat_q, 5'd0} +: 32] = mem_data_i;
                    end
                    if (beat_q == 3'd7) begin
                        beat_d  = 3'd0;
                        ack_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        beat_d = beat_q + 3'd1;
                    end
                end else if (timeout_hit) begin
                    mem_rd_d = 1'b0;
                    mem_we_d = 1'b0;
                    beat_d   = 3'd0;
                    cnt_d    = '0;
                    ack_d    = 1'b1;
                    err_d    = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end

            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            beat_q     <= 3'd0;
            cnt_q      <= '0;
            line_q     <= '0;
            wdata_q    <= '0;
            buf_q      <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            cnt_q      <= cnt_d;
            line_q     <= line_d;
            wdata_q    <= wdata_d;
            buf_q      <= buf_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            mem_rd_q   <= mem_rd_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
        end
    end

    assign data_o     = buf_q;
    assign ack_o      = ack_q;
    assign err_o      = err_q;
    assign mem_rd_o   = mem_rd_q;
    assign mem_we_o   = mem_we_q;
    assign mem_addr_o = mem_addr_q;
    assign mem_data_o = mem_data_q;

endmodule

// File: tb/tb_line_mem_bridge.sv
// Bench for line_mem_bridge: directed and random line transactions against a
// cycle-count model of the beat protocol, with a downstream responder inline.
module tb_line_mem_bridge;

    localparam int unsigned T = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  addr_i;
    logic [255:0] data_i;
    logic [255:0] data_o;
    logic         rd_i;
    logic         we_i;
    logic         ack_o;
    logic         err_o;
    logic [31:0]  mem_addr_o;
    logic [31:0]  mem_data_o;
    logic [31:0]  mem_data_i;
    logic         mem_rd_o;
    logic         mem_we_o;
    logic         mem_ack_i;

    int tests = 0;
    int fails = 0;

    // Per-transaction downstream behaviour: wait states per beat (>= T never acks) and read data.
    int unsigned waits_g[8];
    logic [31:0] rdata_g[8];

    always #5 clk = ~clk;

    line_mem_bridge #(.TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .rst        (rst),
        .addr_i     (addr_i),
        .data_i     (data_i),
        .data_o     (data_o),
        .rd_i       (rd_i),
        .we_i       (we_i),
        .ack_o      (ack_o),
        .err_o      (err_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_o (mem_data_o),
        .mem_data_i (mem_data_i),
        .mem_rd_o   (mem_rd_o),
        .mem_we_o   (mem_we_o),
        .mem_ack_i  (mem_ack_i)
    );

    function automatic void chk(input string tag, input logic [255:0] got,
                                input logic [255:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endfunction

    // Called at the falling edge of the cycle in which the request is first presented
    // (DUT idle). mode 0: drop request after cycle 1; 1: hold until ack; 2: hold through ack.
    task automatic run_txn(input logic rd, input logic we, input logic [31:0] addr,
                           input logic [255:0] wline, input int mode);
        int           nb_exp, ack_exp, sum, c, nbeats, first_c, ack_c;
        int unsigned  inbeat;
        logic         err_exp, is_wr, prev, kind_ok, strobe, got_err;
        logic [255:0] data_exp, got_data;
        logic [31:0]  baddr[8];
        logic [31:0]  bdata[8];

        is_wr    = we;
        nb_exp   = 0;
        ack_exp  = 0;
        sum      = 0;
        err_exp  = 1'b0;
        data_exp = '0;
        for (int j = 0; j < 8; j++) begin
            nb_exp = j + 1;
            if (waits_g[j] >= T) begin
                err_exp = 1'b1;
                ack_exp = sum + int'(T) + 1;
                break;
            end
            if (!is_wr) data_exp[j*32 +: 32] = rdata_g[j];
            sum += int'(waits_g[j]) + 2;
        end
        if (!err_exp) ack_exp = sum;

        chk("strobe_low_at_request", {mem_rd_o, mem_we_o}, 0);
        rd_i      = rd;
        we_i      = we;
        addr_i    = addr;
        data_i    = wline;
        mem_ack_i = 1'b0;

        c        = 0;
        nbeats   = 0;
        first_c  = -1;
        ack_c    = -1;
        inbeat   = 0;
        prev     = 1'b0;
        kind_ok  = 1'b1;
        got_err  = 1'b0;
        got_data = '0;
        while (ack_c < 0 && c < 400) begin
            @(negedge clk);
            c++;
            if (mode == 0 && c == 2) begin
                rd_i = 1'b0;
                we_i = 1'b0;
            end
            strobe = mem_rd_o | mem_we_o;
            if ((mem_rd_o && mem_we_o) || (strobe && (mem_we_o != is_wr))) kind_ok = 1'b0;
            if (strobe && !prev) begin
                if (nbeats < 8) begin
                    baddr[nbeats] = mem_addr_o;
                    bdata[nbeats] = mem_data_o;
                end
                if (nbeats == 0) first_c = c;
                nbeats++;
                inbeat = 0;
            end
            if (strobe && nbeats <= 8) begin
                mem_ack_i  = (inbeat == waits_g[nbeats-1]);
                mem_data_i = mem_ack_i ? rdata_g[nbeats-1] : $urandom;
                inbeat++;
            end else begin
                // Stray acks outside a strobe must be ignored.
                mem_ack_i  = 1'($urandom_range(0, 1));
                mem_data_i = $urandom;
            end
            if (ack_o) begin
                ack_c    = c;
                got_data = data_o;
                got_err  = err_o;
            end
            prev = strobe;
        end
        mem_ack_i = 1'b0;
        if (mode != 2) begin
            rd_i = 1'b0;
            we_i = 1'b0;
        end
        @(negedge clk);

        chk("ack_single_pulse", {ack_o, err_o}, 0);
        chk("ack_cycle", 256'(ack_c), 256'(ack_exp));
        chk("first_strobe_cycle", 256'(first_c), 256'(1));
        chk("beat_count", 256'(nbeats), 256'(nb_exp));
        chk("strobe_kind", kind_ok, 1'b1);
        chk("err_o", got_err, err_exp);
        for (int j = 0; j < nb_exp && j < nbeats && j < 8; j++) begin
            chk("beat_addr", baddr[j], {addr[31:5], 3'(j), 2'b00});
            if (is_wr) chk("beat_data", bdata[j], wline[j*32 +: 32]);
        end
        if (!is_wr) chk("data_o", got_data, data_exp);
    endtask

    initial begin
        logic [255:0] line;
        logic         rd, we;
        int           acks, strobes;

        rst        = 1'b1;
        rd_i       = 1'b0;
        we_i       = 1'b0;
        addr_i     = '0;
        data_i     = '0;
        mem_data_i = '0;
        mem_ack_i  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_ctrl", {ack_o, err_o, mem_rd_o, mem_we_o}, 0);
        chk("reset_data_o", data_o, 0);
        chk("reset_mem_bus", {mem_addr_o, mem_data_o}, 0);

        // Zero-wait read, word k = 0x1000_0000 + k.
        for (int k = 0; k < 8; k++) begin
            waits_g[k] = 0;
            rdata_g[k] = 32'h1000_0000 + 32'(k);
        end
        run_txn(1'b1, 1'b0, 32'h0000_2013, '0, 1);

        // Write with three wait states per beat.
        for (int k = 0; k < 8; k++) begin
            waits_g[k] = 3;
            line[k*32 +: 32] = 32'hA5A5_0000 + 32'(k);
        end
        run_txn(1'b0, 1'b1, 32'h0040_0000, line, 1);

        // Read with beat 3 never acknowledged.
        for (int k = 0; k < 8; k++) begin
            waits_g[k] = (k == 3) ? 9 : 0;
            rdata_g[k] = $urandom;
        end
        run_txn(1'b1, 1'b0, 32'h1234_5660, '0, 1);

        // Back-to-back reads with rd_i held through the ack cycle.
        for (int k = 0; k < 8; k++) waits_g[k] = 0;
        run_txn(1'b1, 1'b0, 32'h0000_8000, '0, 2);
        run_txn(1'b1, 1'b0, 32'h0000_9000, '0, 1);

        // Reset during beat 5 of a zero-wait write.
        we_i   = 1'b1;
        addr_i = 32'h00AB_C000;
        data_i = {8{32'hDEAD_BEEF}};
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            mem_ack_i = mem_we_o;
        end
        chk("beat5_strobe", {mem_we_o, mem_addr_o}, {1'b1, 32'h00AB_C014});
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ctrl", {ack_o, err_o, mem_rd_o, mem_we_o}, 0);
        chk("midrst_bus", {mem_addr_o, mem_data_o}, 0);
        chk("midrst_data_o", data_o, 0);
        rst       = 1'b0;
        we_i      = 1'b0;
        mem_ack_i = 1'b0;
        acks      = 0;
        strobes   = 0;
        repeat (20) begin
            @(negedge clk);
            acks    += int'(ack_o);
            strobes += int'(mem_rd_o | mem_we_o);
        end
        chk("midrst_no_ack", 256'(acks), 0);
        chk("midrst_no_strobe", 256'(strobes), 0);
        for (int k = 0; k < 8; k++) begin
            waits_g[k] = 1;
            rdata_g[k] = $urandom;
        end
        run_txn(1'b1, 1'b0, 32'h0000_0040, '0, 1);

        // Read and write together: write wins.
        for (int k = 0; k < 8; k++) begin
            waits_g[k] = 0;
            line[k*32 +: 32] = $urandom;
        end
        run_txn(1'b1, 1'b1, 32'h5555_0000, line, 1);

        // Random mix, occasionally with a dead beat.
        for (int i = 0; i < 12; i++) begin
            rd = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            if (!rd && !we) rd = 1'b1;
            for (int k = 0; k < 8; k++) begin
                waits_g[k]       = $urandom_range(0, 3);
                rdata_g[k]       = $urandom;
                line[k*32 +: 32] = $urandom;
            end
            if ($urandom_range(0, 3) == 0) waits_g[$urandom_range(0, 7)] = 9;
            run_txn(rd, we, $urandom, line, int'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
